// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multu/divu unit with architectural HI/LO registers.
// Runs one shift-add or restoring-divide step per cycle over WIDTH cycles and requests a pipeline stall while busy.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             rd_req,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [CW-1:0]      r_count;
  logic               r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [WIDTH:0]     w_remSh;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_divNext;
  logic [2*WIDTH-1:0] w_accNext;
  logic               w_busy;

  // Multiply: r_acc holds {partial product, remaining multiplier}; carry from the add shifts into the top.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mulNext = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: r_acc holds {remainder, dividend/quotient}; a set top bit of the shifted remainder means it already exceeds the divisor.
  assign w_remSh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial   = w_remSh - {1'b0, r_opnd};
  assign w_ge      = w_remSh[WIDTH] | ~w_trial[WIDTH];
  assign w_divNext = {(w_ge ? w_trial[WIDTH-1:0] : w_remSh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  assign w_accNext = r_op ? w_divNext : w_mulNext;

  assign w_busy = (r_state == S_RUN);
  assign busy   = w_busy;
  assign done   = r_done;
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign stall  = w_busy & (rd_req | start | wr_hi | wr_lo);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_op    <= 1'b0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_hi) r_hi <= wdata;
          if (wr_lo) r_lo <= wdata;
          if (start) begin
            r_op    <= op;
            r_count <= '0;
            r_state <= S_RUN;
            if (op) begin
              r_acc  <= {{WIDTH{1'b0}}, srca};
              r_opnd <= srcb;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, srcb};
              r_opnd <= srca;
            end
          end
        end
        default: begin
          r_acc   <= w_accNext;
          r_count <= r_count + 1'b1;
          // Final iteration: commit straight from the next-state value so the result lands on this edge.
          if (r_count == LAST) begin
            r_hi    <= w_accNext[2*WIDTH-1:WIDTH];
            r_lo    <= w_accNext[WIDTH-1:0];
            r_done  <= 1'b1;
            r_count <= '0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32).
// Each scenario task drives its own stimulus and compares against hand-computed results.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        rd_req;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int vectors = 0;
  int miscompares = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .rd_req(rd_req), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs;
    start = 1'b0; op = 1'b0; srca = '0; srcb = '0;
    rd_req = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
  endtask

  task automatic test_reset;
    clearInputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    vectors++;
    if ({hi, lo, busy, done, stall} !== 67'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: hi=%h lo=%h busy=%b done=%b stall=%b, want all zero", hi, lo, busy, done, stall);
    end
  endtask

  task automatic test_multu;
    logic [31:0] tA [3] = '{32'hFFFFFFFF, 32'h12345678, 32'h80000000};
    logic [31:0] tB [3] = '{32'hFFFFFFFF, 32'h00000010, 32'h00000002};
    logic [31:0] tH [3] = '{32'hFFFFFFFE, 32'h00000001, 32'h00000001};
    logic [31:0] tL [3] = '{32'h00000001, 32'h23456780, 32'h00000000};
    for (int v = 0; v < 3; v++) begin
      int busyCnt = 0, doneCnt = 0, doneAt = -1;
      start = 1'b1; op = 1'b0; srca = tA[v]; srcb = tB[v];
      tick();
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (busy) busyCnt++;
        if (done) begin
          doneCnt++;
          doneAt = c;
          vectors++;
          if (hi !== tH[v] || lo !== tL[v]) begin
            miscompares++;
            $display("[TB] FAIL multu_result[%0d]: hi=%h lo=%h, want hi=%h lo=%h", v, hi, lo, tH[v], tL[v]);
          end
        end
        tick();
      end
      vectors++;
      if (busyCnt != 32 || doneCnt != 1 || doneAt != 32) begin
        miscompares++;
        $display("[TB] FAIL multu_timing[%0d]: busy=%0d done=%0d at %0d, want busy=32 done=1 at 32", v, busyCnt, doneCnt, doneAt);
      end
    end
  endtask

  task automatic test_divu;
    logic [31:0] tA [3] = '{32'd100, 32'h00001234, 32'hFFFFFFFF};
    logic [31:0] tB [3] = '{32'd7,   32'h00000000, 32'h00000010};
    logic [31:0] tH [3] = '{32'd2,   32'h00001234, 32'h0000000F};
    logic [31:0] tL [3] = '{32'd14,  32'hFFFFFFFF, 32'h0FFFFFFF};
    for (int v = 0; v < 3; v++) begin
      int doneAt = -1;
      start = 1'b1; op = 1'b1; srca = tA[v]; srcb = tB[v];
      tick();
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (done && doneAt < 0) begin
          doneAt = c;
          vectors++;
          if (hi !== tH[v] || lo !== tL[v]) begin
            miscompares++;
            $display("[TB] FAIL divu_result[%0d]: hi=%h lo=%h, want hi=%h lo=%h", v, hi, lo, tH[v], tL[v]);
          end
        end
        tick();
      end
      vectors++;
      if (doneAt != 32) begin
        miscompares++;
        $display("[TB] FAIL divu_latency[%0d]: done at %0d, want 32", v, doneAt);
      end
    end
  endtask

  task automatic test_stall_read;
    int stallBad = 0, loBad = 0;
    wr_lo = 1'b1; wdata = 32'hAAAA5555;
    tick();
    wr_lo = 1'b0; rd_req = 1'b1;
    #1;
    vectors++;
    if (lo !== 32'hAAAA5555 || stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mtlo_idle_read: lo=%h stall=%b, want lo=aaaa5555 stall=0", lo, stall);
    end
    rd_req = 1'b0; start = 1'b1; op = 1'b0; srca = 32'd3; srcb = 32'd5;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_idle_stall: stall=%b, want 0", stall);
    end
    tick();
    start = 1'b0; rd_req = 1'b1;
    for (int c = 0; c < 32; c++) begin
      #1;
      if (stall !== 1'b1) stallBad++;
      if (lo !== 32'hAAAA5555) loBad++;
      tick();
    end
    vectors++;
    if (stallBad != 0 || loBad != 0) begin
      miscompares++;
      $display("[TB] FAIL run_stall_hold: %0d cycles stall low, %0d cycles lo changed, want 0 and 0", stallBad, loBad);
    end
    vectors++;
    if (done !== 1'b1 || stall !== 1'b0 || lo !== 32'd15 || hi !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL done_cycle_read: done=%b stall=%b hi=%h lo=%h, want 1 0 0 f", done, stall, hi, lo);
    end
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored;
    int doneAt = -1;
    logic sawStall = 1'b0;
    start = 1'b1; op = 1'b0; srca = 32'h00001000; srcb = 32'h00000010;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) begin
        start = 1'b1; op = 1'b1; srca = 32'd9; srcb = 32'd3;
        #1;
        sawStall = stall;
      end
      if (c == 6) start = 1'b0;
      if (done && doneAt < 0) begin
        doneAt = c;
        vectors++;
        if (hi !== 32'd0 || lo !== 32'h00010000) begin
          miscompares++;
          $display("[TB] FAIL restart_result: hi=%h lo=%h, want hi=0 lo=00010000", hi, lo);
        end
      end
      tick();
    end
    vectors++;
    if (doneAt != 32 || sawStall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL restart_ignored: done at %0d stall=%b, want 32 and 1", doneAt, sawStall);
    end
  endtask

  task automatic test_reset_mid;
    int doneAt = -1;
    start = 1'b1; op = 1'b1; srca = 32'hDEADBEEF; srcb = 32'd3;
    tick();
    start = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_abort: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
    end
    start = 1'b1; op = 1'b0; srca = 32'd6; srcb = 32'd7;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done && doneAt < 0) begin
        doneAt = c;
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd42) begin
          miscompares++;
          $display("[TB] FAIL post_reset_multu: hi=%h lo=%h, want hi=0 lo=2a", hi, lo);
        end
      end
      tick();
    end
    vectors++;
    if (doneAt != 32) begin
      miscompares++;
      $display("[TB] FAIL post_reset_latency: done at %0d, want 32", doneAt);
    end
  endtask

  task automatic test_start_with_write;
    int doneAt = -1;
    start = 1'b1; op = 1'b0; srca = 32'h00010000; srcb = 32'h00010000;
    wr_hi = 1'b1; wdata = 32'h12345678;
    tick();
    start = 1'b0; wr_hi = 1'b0;
    vectors++;
    if (hi !== 32'h12345678 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_with_mthi: hi=%h busy=%b, want hi=12345678 busy=1", hi, busy);
    end
    for (int c = 0; c < 40; c++) begin
      if (c == 3) begin
        wr_lo = 1'b1; wdata = 32'h0000FFFF;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL mtlo_busy_stall: stall=%b, want 1", stall);
        end
      end
      if (c == 4) begin
        wr_lo = 1'b0;
        vectors++;
        if (lo !== 32'd42 || hi !== 32'h12345678) begin
          miscompares++;
          $display("[TB] FAIL mtlo_busy_ignored: hi=%h lo=%h, want hi=12345678 lo=2a", hi, lo);
        end
      end
      if (done && doneAt < 0) begin
        doneAt = c;
        vectors++;
        if (hi !== 32'd1 || lo !== 32'd0) begin
          miscompares++;
          $display("[TB] FAIL commit_overwrites_hi: hi=%h lo=%h, want hi=1 lo=0", hi, lo);
        end
      end
      tick();
    end
    vectors++;
    if (doneAt != 32) begin
      miscompares++;
      $display("[TB] FAIL start_write_latency: done at %0d, want 32", doneAt);
    end
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    test_reset();
    test_multu();
    test_divu();
    test_stall_read();
    test_start_ignored();
    test_reset_mid();
    test_start_with_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
